// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sram_ctrl_pkg
// Purpose : Shared definitions for the asynchronous SRAM controller. It holds
//           the write-sequence state encodings, which the bench also uses, and
//           a helper that sizes the phase timer.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package sram_ctrl_pkg;

  localparam int SRAM_ST_WIDTH = 2;

  localparam logic [SRAM_ST_WIDTH-1:0] SRAM_ST_IDLE  = 2'd0;
  localparam logic [SRAM_ST_WIDTH-1:0] SRAM_ST_SETUP = 2'd1;
  localparam logic [SRAM_ST_WIDTH-1:0] SRAM_ST_PULSE = 2'd2;
  localparam logic [SRAM_ST_WIDTH-1:0] SRAM_ST_HOLD  = 2'd3;

  // The counter must hold the largest phase length minus one. The result is
  // never less than one bit.
  function automatic int timer_width(input int setup_c, input int we_c, input int hold_c);
    int m;
    int w;
    m = setup_c;
    if (we_c > m)   m = we_c;
    if (hold_c > m) m = hold_c;
    w = $clog2(m + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_ctrl_phase_timer.sv
`default_nettype none
// ============================================================================
// Module  : sram_ctrl_phase_timer
// Purpose : A down-counter for phase timing. It loads a value, decrements it,
//           and signals when the count reaches zero. Other peripheral
//           controllers can reuse it.
// Ports   : clk, rst          clock, synchronous active-high reset
//           i_load/i_load_val load the counter (takes priority over i_dec)
//           i_dec             decrement; the counter saturates at zero
//           o_zero            count == 0
// Rev     : 1.0  initial release
// ============================================================================
module sram_ctrl_phase_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sram_ctrl
// Purpose : Controller for one external asynchronous 32-bit SRAM.
//           Reads are combinational. A write latches its address and data,
//           then drives WE_N through a timed SETUP/PULSE/HOLD sequence.
//           mem_busy stays high for the whole write.
// Ports   : clk, rst        clock, synchronous active-high reset
//           mem_addr        word address from the MMU
//           mem_data_in     write data from the MMU
//           mem_data_out    read data to the MMU (0 if out of range or busy)
//           mem_is_write    write request, one-cycle pulse
//           mem_busy        controller busy
//           sram_addr       SRAM address pins
//           sram_data       SRAM data bus; tri-stated except during a write
//           sram_ce_n       chip enable (tied active)
//           sram_oe_n       output enable, active low
//           sram_we_n       write enable, active low, registered
// Rev     : 1.0  initial release
// ============================================================================
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = 20,
  parameter int SETUP_CYCLES = 1,
  parameter int WE_CYCLES    = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_data_in,
  output logic [31:0]           mem_data_out,
  input  logic                  mem_is_write,
  output logic                  mem_busy,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [31:0]           sram_data,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n
);

  localparam int TIMER_W = timer_width(SETUP_CYCLES, WE_CYCLES, HOLD_CYCLES);

  localparam logic [TIMER_W-1:0] SETUP_LOAD = TIMER_W'(SETUP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WE_LOAD    = TIMER_W'(WE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_LOAD  = TIMER_W'(HOLD_CYCLES - 1);

  logic [SRAM_ST_WIDTH-1:0] r_state;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [31:0]              r_wdata;
  logic                     r_in_range;
  logic                     r_we_n;

  logic                     w_idle;
  logic                     w_start;
  logic                     w_in_range;
  logic                     w_zero;
  logic                     w_tmr_load;
  logic [TIMER_W-1:0]       w_tmr_val;
  logic [31:0]              w_addr_hi;

  // Address bits above the SRAM width must all be zero. A shift works for
  // any ADDR_WIDTH, including the full 32 bits.
  assign w_addr_hi  = mem_addr >> ADDR_WIDTH;
  assign w_in_range = (w_addr_hi == 32'd0);

  assign w_idle  = (r_state == SRAM_ST_IDLE);
  assign w_start = w_idle && mem_is_write;

  // The timer is reloaded when a request starts and at every phase boundary.
  // It is loaded with the length of the phase being entered, minus one.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    if (w_start) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = SETUP_LOAD;
    end else if (!w_idle && w_zero) begin
      w_tmr_load = 1'b1;
      case (r_state)
        SRAM_ST_SETUP: w_tmr_val = WE_LOAD;
        SRAM_ST_PULSE: w_tmr_val = HOLD_LOAD;
        default:       w_tmr_val = '0;
      endcase
    end
  end

  sram_ctrl_phase_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (!w_idle),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= SRAM_ST_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_in_range <= 1'b0;
      r_we_n     <= 1'b1;
    end else begin
      case (r_state)
        SRAM_ST_IDLE: begin
          if (mem_is_write) begin
            r_addr     <= mem_addr[ADDR_WIDTH-1:0];
            r_wdata    <= mem_data_in;
            r_in_range <= w_in_range;
            r_state    <= SRAM_ST_SETUP;
          end
        end
        SRAM_ST_SETUP: begin
          if (w_zero) begin
            r_state <= SRAM_ST_PULSE;
            // An out-of-range write runs its full timing, but WE_N is never
            // asserted for it.
            r_we_n  <= !r_in_range;
          end
        end
        SRAM_ST_PULSE: begin
          if (w_zero) begin
            r_state <= SRAM_ST_HOLD;
            r_we_n  <= 1'b1;
          end
        end
        SRAM_ST_HOLD: begin
          if (w_zero) begin
            r_state <= SRAM_ST_IDLE;
          end
        end
        default: begin
          r_state <= SRAM_ST_IDLE;
          r_we_n  <= 1'b1;
        end
      endcase
    end
  end

  assign sram_ce_n    = 1'b0;
  assign sram_oe_n    = !w_idle;
  assign sram_we_n    = r_we_n;
  assign sram_addr    = w_idle ? mem_addr[ADDR_WIDTH-1:0] : r_addr;
  assign sram_data    = w_idle ? 32'bz : r_wdata;
  // mem_is_write raises busy combinationally, so the MMU stalls in the same
  // cycle it makes the request.
  assign mem_busy     = !w_idle || mem_is_write;
  assign mem_data_out = (w_idle && w_in_range) ? sram_data : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_ctrl
// Purpose : Self-checking bench for sram_ctrl. The bench contains an async
//           SRAM model that writes on the rising edge of WE_N. It also keeps a
//           reference model that counts the cycles since each write request.
//           The driver pushes the expected value of every cycle into a queue,
//           and a monitor on the falling edge pops and compares it.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  localparam int AW = 20;
  localparam int S  = 1;
  localparam int W  = 2;
  localparam int H  = 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [31:0]    mem_addr = '0;
  logic [31:0]    mem_data_in = '0;
  logic [31:0]    mem_data_out;
  logic           mem_is_write = 1'b0;
  logic           mem_busy;
  logic [AW-1:0]  sram_addr;
  wire  [31:0]    sram_data;
  logic           sram_ce_n;
  logic           sram_oe_n;
  logic           sram_we_n;

  always #5 clk = ~clk;

  sram_ctrl #(
    .ADDR_WIDTH   (AW),
    .SETUP_CYCLES (S),
    .WE_CYCLES    (W),
    .HOLD_CYCLES  (H)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_is_write (mem_is_write),
    .mem_busy     (mem_busy),
    .sram_addr    (sram_addr),
    .sram_data    (sram_data),
    .sram_ce_n    (sram_ce_n),
    .sram_oe_n    (sram_oe_n),
    .sram_we_n    (sram_we_n)
  );

  // Behavioural async SRAM chip
  logic [31:0] sram_mem [0:(1<<AW)-1];
  logic        armed = 1'b0;

  assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_mem[sram_addr] : 32'bz;

  always @(posedge sram_we_n) begin
    if (armed) sram_mem[sram_addr] <= sram_data;
  end

  // Reference model
  logic [31:0] ref_mem [0:(1<<AW)-1];
  bit          wr_active = 1'b0;
  int          wr_k = 0;
  logic [19:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  bit          wr_inr = 1'b0;

  typedef struct {
    string       tag;
    logic        busy;
    logic        we_n;
    logic        oe_n;
    logic        drive;
    logic [19:0] addr;
    logic [31:0] dout;
    logic [31:0] bus;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic bit in_range(input logic [31:0] a);
    return (a[31:20] == 12'd0);
  endfunction

  // One cycle: apply the inputs, predict the outputs, then advance the model
  // across the clock edge.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w,
                      input logic r, input string tag);
    exp_t e;
    mem_addr     = a;
    mem_data_in  = d;
    mem_is_write = w;
    rst          = r;
    e.tag = tag;
    if (!wr_active) begin
      e.busy  = w;
      e.we_n  = 1'b1;
      e.oe_n  = 1'b0;
      e.drive = 1'b0;
      e.addr  = a[19:0];
      e.dout  = in_range(a) ? ref_mem[a[19:0]] : 32'd0;
      e.bus   = 32'd0;
    end else begin
      e.busy  = 1'b1;
      e.we_n  = !(wr_inr && (wr_k > S) && (wr_k <= S + W));
      e.oe_n  = 1'b1;
      e.drive = 1'b1;
      e.addr  = wr_addr;
      e.dout  = 32'd0;
      e.bus   = wr_data;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (r) begin
      wr_active = 1'b0;
    end else if (wr_active) begin
      if (wr_k == S + W + H) begin
        if (wr_inr) ref_mem[wr_addr] = wr_data;
        wr_active = 1'b0;
      end else begin
        wr_k++;
      end
    end else if (w) begin
      wr_active = 1'b1;
      wr_k      = 1;
      wr_addr   = a[19:0];
      wr_data   = d;
      wr_inr    = in_range(a);
    end
    mem_is_write = 1'b0;
    rst          = 1'b0;
  endtask

  task automatic chk(input string tag, input string name, input logic [31:0] act,
                     input logic [31:0] want);
    if (act !== want) begin
      n_err++;
      $display("FAIL %s.%s: got %08h want %08h", tag, name, act, want);
    end
  endtask

  // Monitor: compare every cycle in the middle of the clock period
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      chk(e.tag, "busy", 32'(mem_busy), 32'(e.busy));
      chk(e.tag, "we_n", 32'(sram_we_n), 32'(e.we_n));
      chk(e.tag, "oe_n", 32'(sram_oe_n), 32'(e.oe_n));
      chk(e.tag, "ce_n", 32'(sram_ce_n), 32'd0);
      chk(e.tag, "addr", 32'(sram_addr), 32'(e.addr));
      chk(e.tag, "dout", mem_data_out, e.dout);
      if (e.drive) chk(e.tag, "bus", sram_data, e.bus);
    end
  end

  localparam logic [31:0] RST_ADDR = 32'h0007_FFF0;

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      sram_mem[i] = d;
      ref_mem[i]  = d;
    end
    sram_mem[20'h10] = 32'hDEAD_BEEF;
    ref_mem[20'h10]  = 32'hDEAD_BEEF;
    sram_mem[RST_ADDR[19:0]] = 32'd0;
    ref_mem[RST_ADDR[19:0]]  = 32'd0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    armed = 1'b1;

    // 1: idle read after reset
    step(32'h10, 32'd0, 1'b0, 1'b0, "t1_read");
    step(32'h10, 32'd0, 1'b0, 1'b0, "t1_read2");

    // 2 and 3: write 0x20; the MMU inputs change while the write is in progress
    step(32'h20, 32'h1234_5678, 1'b1, 1'b0, "t2_req");
    for (int i = 0; i < 4; i++) step(32'h30, 32'd0, 1'b0, 1'b0, "t3_busy");
    step(32'h20, 32'd0, 1'b0, 1'b0, "t2_readback");
    step(32'h30, 32'd0, 1'b0, 1'b0, "t3_untouched");

    // 4: out-of-range read and write
    step(32'h0010_0000, 32'd0, 1'b0, 1'b0, "t4_oor_read");
    step(32'h0010_0000, 32'hCAFE_F00D, 1'b1, 1'b0, "t4_oor_req");
    for (int i = 0; i < 4; i++) step(32'h0010_0000, 32'd0, 1'b0, 1'b0, "t4_oor_busy");
    step(32'h0, 32'd0, 1'b0, 1'b0, "t4_read0");
    step(32'h10, 32'd0, 1'b0, 1'b0, "t4_read10");

    // 5: reset during PULSE
    step(RST_ADDR, 32'hA5A5_5A5A, 1'b1, 1'b0, "t5_req");
    step(32'h10, 32'd0, 1'b0, 1'b0, "t5_setup");
    step(32'h10, 32'd0, 1'b0, 1'b1, "t5_pulse_rst");
    step(32'h10, 32'd0, 1'b0, 1'b0, "t5_after_rst");

    // 6: back-to-back writes
    step(32'h40, 32'h1111_2222, 1'b1, 1'b0, "t6_req1");
    for (int i = 0; i < 4; i++) step(32'h40, 32'd0, 1'b0, 1'b0, "t6_busy1");
    step(32'h41, 32'h3333_4444, 1'b1, 1'b0, "t6_req2");
    for (int i = 0; i < 4; i++) step(32'h41, 32'd0, 1'b0, 1'b0, "t6_busy2");
    step(32'h40, 32'd0, 1'b0, 1'b0, "t6_rd1");
    step(32'h41, 32'd0, 1'b0, 1'b0, "t6_rd2");

    // Randomized traffic, including requests issued while busy
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 7) a = 32'($urandom_range(0, 255));
      else a = {12'($urandom_range(1, 4095)), 20'($urandom_range(0, 255))};
      d = $urandom;
      step(a, d, ($urandom_range(0, 3) == 0), 1'b0, "rnd");
    end
    for (int i = 0; i < 6; i++) step(32'($urandom_range(0, 255)), 32'd0, 1'b0, 1'b0, "rnd_tail");

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
